// File: rtl/usb_serial_mmio.sv
// ============================================================================
// Module      : usb_serial_mmio
// Description : Memory-mapped byte-serial bridge between CPU registers and
//               USB CDC byte streams, with RX/TX FIFOs and level interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_serial_mmio #(
    parameter int DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sel_i,
    input  logic       read_i,
    input  logic       write_i,
    input  logic [1:0] addr_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       rx_irq_o,
    output logic       tx_irq_o,
    output logic [7:0] in_data_o,
    output logic       in_valid_o,
    input  logic       in_ready_i,
    input  logic [7:0] out_data_i,
    input  logic       out_valid_i,
    output logic       out_ready_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] c_ADDR_DATA   = 2'd0;
    localparam logic [1:0] c_ADDR_STATUS = 2'd1;
    localparam logic [1:0] c_ADDR_IRQEN  = 2'd2;
    localparam logic [1:0] c_ADDR_RXCNT  = 2'd3;

    logic [7:0]    r_rx_mem [DEPTH];
    logic [7:0]    r_tx_mem [DEPTH];
    logic [AW-1:0] r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
    logic [CW-1:0] r_rx_cnt, r_tx_cnt;
    logic          r_ovf, r_udr;
    logic [1:0]    r_irq_en;
    logic [7:0]    r_data;
    logic          r_rx_irq, r_tx_irq;

    logic       w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic       w_rd, w_wr;
    logic       w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
    logic       w_ovf_set, w_udr_set, w_ovf_clr, w_udr_clr;
    logic [7:0] w_status;
    logic [7:0] w_rd_data;

    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == CW'(DEPTH));
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == CW'(DEPTH));

    assign w_rd = sel_i & read_i;
    assign w_wr = sel_i & write_i;

    // No look-ahead: a full FIFO refuses a push even if it pops this cycle.
    assign w_rx_push = out_valid_i & out_ready_o;
    assign w_rx_pop  = w_rd & (addr_i == c_ADDR_DATA) & ~w_rx_empty;
    assign w_tx_push = w_wr & (addr_i == c_ADDR_DATA) & ~w_tx_full;
    assign w_tx_pop  = in_valid_o & in_ready_i;

    assign w_udr_set = w_rd & (addr_i == c_ADDR_DATA) & w_rx_empty;
    assign w_ovf_set = w_wr & (addr_i == c_ADDR_DATA) & w_tx_full;
    assign w_ovf_clr = w_wr & (addr_i == c_ADDR_STATUS) & data_i[2];
    assign w_udr_clr = w_wr & (addr_i == c_ADDR_STATUS) & data_i[3];

    assign w_status = {3'b000, w_tx_empty, r_udr, r_ovf, ~w_tx_full, ~w_rx_empty};

    always_comb begin
        w_rd_data = 8'h00;
        case (addr_i)
            c_ADDR_DATA:   w_rd_data = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];
            c_ADDR_STATUS: w_rd_data = w_status;
            c_ADDR_IRQEN:  w_rd_data = {6'b000000, r_irq_en};
            c_ADDR_RXCNT:  w_rd_data = 8'(r_rx_cnt);
            default:       w_rd_data = 8'h00;
        endcase
    end

    // Storage arrays carry no reset; validity is tracked by pointers/counts.
    always_ff @(posedge clk_i) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= out_data_i;
        if (w_tx_push) r_tx_mem[r_tx_wp] <= data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_rx_cnt <= '0;
            r_tx_cnt <= '0;
            r_ovf    <= 1'b0;
            r_udr    <= 1'b0;
            r_irq_en <= 2'b00;
            r_data   <= 8'h00;
            r_rx_irq <= 1'b0;
            r_tx_irq <= 1'b0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
            r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
            r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);

            // A set event in the same cycle as a clear takes priority.
            r_ovf <= w_ovf_set | (r_ovf & ~w_ovf_clr);
            r_udr <= w_udr_set | (r_udr & ~w_udr_clr);

            if (w_wr && addr_i == c_ADDR_IRQEN) r_irq_en <= data_i[1:0];
            if (w_rd) r_data <= w_rd_data;

            r_rx_irq <= r_irq_en[0] & ~w_rx_empty;
            r_tx_irq <= r_irq_en[1] & w_tx_empty;
        end
    end

    assign data_o      = r_data;
    assign rx_irq_o    = r_rx_irq;
    assign tx_irq_o    = r_tx_irq;
    assign in_valid_o  = ~w_tx_empty;
    assign in_data_o   = r_tx_mem[r_tx_rp];
    assign out_ready_o = ~rst_i & ~w_rx_full;

endmodule

`default_nettype wire

// File: tb/tb_usb_serial_mmio.sv
// ============================================================================
// Module      : tb_usb_serial_mmio
// Description : Self-checking bench for usb_serial_mmio: directed scenarios
//               plus randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_serial_mmio;

    localparam int DEPTH = 16;

    logic       clk_i = 1'b0;
    logic       rst_i, sel_i, read_i, write_i;
    logic [1:0] addr_i;
    logic [7:0] data_i, data_o;
    logic       rx_irq_o, tx_irq_o;
    logic [7:0] in_data_o;
    logic       in_valid_o, in_ready_i;
    logic [7:0] out_data_i;
    logic       out_valid_i, out_ready_o;

    int n_checks = 0;
    int n_err    = 0;

    usb_serial_mmio #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .sel_i(sel_i), .read_i(read_i),
        .write_i(write_i), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
        .rx_irq_o(rx_irq_o), .tx_irq_o(tx_irq_o), .in_data_o(in_data_o),
        .in_valid_o(in_valid_o), .in_ready_i(in_ready_i), .out_data_i(out_data_i),
        .out_valid_i(out_valid_i), .out_ready_o(out_ready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs;
        sel_i = 0; read_i = 0; write_i = 0; addr_i = 0; data_i = 0;
        in_ready_i = 0; out_data_i = 0; out_valid_i = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_i = 1;
        tick(); tick();
        rst_i = 0;
        tick();
    endtask

    task automatic cpu_rd(input logic [1:0] a);
        sel_i = 1; read_i = 1; addr_i = a;
        tick();
        sel_i = 0; read_i = 0;
    endtask

    task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
        sel_i = 1; write_i = 1; addr_i = a; data_i = d;
        tick();
        sel_i = 0; write_i = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_i = 1;
        tick();
        n_checks++; if (out_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_out_ready: got %b expected 0", out_ready_o); end
        n_checks++; if (in_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_in_valid: got %b expected 0", in_valid_o); end
        n_checks++; if (data_o !== 8'h00) begin n_err++; $display("FAIL rst_data_o: got %h expected 00", data_o); end
        n_checks++; if ({rx_irq_o, tx_irq_o} !== 2'b00) begin n_err++; $display("FAIL rst_irqs: got %b expected 00", {rx_irq_o, tx_irq_o}); end
        rst_i = 0;
        tick();
        n_checks++; if (out_ready_o !== 1'b1) begin n_err++; $display("FAIL idle_out_ready: got %b expected 1", out_ready_o); end
        cpu_rd(2'd1);
        n_checks++; if (data_o !== 8'h12) begin n_err++; $display("FAIL idle_status: got %h expected 12", data_o); end
        cpu_rd(2'd3);
        n_checks++; if (data_o !== 8'h00) begin n_err++; $display("FAIL idle_rxcount: got %h expected 00", data_o); end
    endtask

    task automatic test_rx_basic;
        do_reset();
        out_valid_i = 1; out_data_i = 8'h41; tick();
        out_data_i = 8'h42; tick();
        out_valid_i = 0;
        cpu_rd(2'd3);
        n_checks++; if (data_o !== 8'h02) begin n_err++; $display("FAIL rx_count2: got %h expected 02", data_o); end
        cpu_rd(2'd0);
        n_checks++; if (data_o !== 8'h41) begin n_err++; $display("FAIL rx_first: got %h expected 41", data_o); end
        cpu_rd(2'd0);
        n_checks++; if (data_o !== 8'h42) begin n_err++; $display("FAIL rx_second: got %h expected 42", data_o); end
        cpu_rd(2'd0);
        n_checks++; if (data_o !== 8'h00) begin n_err++; $display("FAIL rx_underrun_data: got %h expected 00", data_o); end
        cpu_rd(2'd1);
        n_checks++; if (data_o !== 8'h1A) begin n_err++; $display("FAIL rx_underrun_status: got %h expected 1a", data_o); end
        cpu_wr(2'd1, 8'h08);
        cpu_rd(2'd1);
        n_checks++; if (data_o !== 8'h12) begin n_err++; $display("FAIL underrun_clear: got %h expected 12", data_o); end
    endtask

    task automatic test_rx_full;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            out_valid_i = 1; out_data_i = 8'(8'h60 + i);
            n_checks++; if (out_ready_o !== 1'b1) begin n_err++; $display("FAIL fill_ready[%0d]: got %b expected 1", i, out_ready_o); end
            tick();
        end
        out_data_i = 8'h70;
        n_checks++; if (out_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b expected 0", out_ready_o); end
        cpu_rd(2'd0);
        n_checks++; if (data_o !== 8'h60) begin n_err++; $display("FAIL full_pop_data: got %h expected 60", data_o); end
        n_checks++; if (out_ready_o !== 1'b1) begin n_err++; $display("FAIL after_pop_ready: got %b expected 1", out_ready_o); end
        tick();
        out_valid_i = 0;
        cpu_rd(2'd3);
        n_checks++; if (data_o !== 8'(DEPTH)) begin n_err++; $display("FAIL refill_count: got %h expected %h", data_o, 8'(DEPTH)); end
        for (int i = 1; i <= DEPTH; i++) begin
            cpu_rd(2'd0);
            n_checks++; if (data_o !== 8'(8'h60 + i)) begin n_err++; $display("FAIL drain[%0d]: got %h expected %h", i, data_o, 8'(8'h60 + i)); end
        end
    endtask

    task automatic test_tx;
        do_reset();
        in_ready_i = 0;
        for (int i = 0; i < DEPTH; i++) cpu_wr(2'd0, 8'(8'h10 + i));
        cpu_wr(2'd0, 8'h20);
        n_checks++; if (in_valid_o !== 1'b1 || in_data_o !== 8'h10) begin n_err++; $display("FAIL tx_hold: got v=%b d=%h expected v=1 d=10", in_valid_o, in_data_o); end
        cpu_rd(2'd1);
        n_checks++; if (data_o !== 8'h04) begin n_err++; $display("FAIL tx_overflow_status: got %h expected 04", data_o); end
        n_checks++; if (in_data_o !== 8'h10) begin n_err++; $display("FAIL tx_stable: got %h expected 10", in_data_o); end
        in_ready_i = 1;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++; if (in_valid_o !== 1'b1 || in_data_o !== 8'(8'h10 + i)) begin n_err++; $display("FAIL tx_out[%0d]: got v=%b d=%h expected v=1 d=%h", i, in_valid_o, in_data_o, 8'(8'h10 + i)); end
            tick();
        end
        n_checks++; if (in_valid_o !== 1'b0) begin n_err++; $display("FAIL tx_drained: got %b expected 0", in_valid_o); end
        in_ready_i = 0;
    endtask

    task automatic test_irq;
        do_reset();
        cpu_wr(2'd2, 8'hFF);
        cpu_rd(2'd2);
        n_checks++; if (data_o !== 8'h03) begin n_err++; $display("FAIL irqen_read: got %h expected 03", data_o); end
        n_checks++; if ({rx_irq_o, tx_irq_o} !== 2'b01) begin n_err++; $display("FAIL irq_idle: got %b expected 01", {rx_irq_o, tx_irq_o}); end
        out_valid_i = 1; out_data_i = 8'h5C; tick();
        out_valid_i = 0;
        n_checks++; if (rx_irq_o !== 1'b0) begin n_err++; $display("FAIL rx_irq_early: got %b expected 0", rx_irq_o); end
        tick();
        n_checks++; if (rx_irq_o !== 1'b1) begin n_err++; $display("FAIL rx_irq_rise: got %b expected 1", rx_irq_o); end
        cpu_rd(2'd0);
        n_checks++; if (rx_irq_o !== 1'b1) begin n_err++; $display("FAIL rx_irq_hold: got %b expected 1", rx_irq_o); end
        tick();
        n_checks++; if (rx_irq_o !== 1'b0 || tx_irq_o !== 1'b1) begin n_err++; $display("FAIL rx_irq_fall: got %b%b expected 01", rx_irq_o, tx_irq_o); end
    endtask

    task automatic test_same_cycle_and_reset;
        do_reset();
        out_valid_i = 1; out_data_i = 8'hA5; tick();
        out_data_i = 8'hB6; sel_i = 1; read_i = 1; addr_i = 2'd0;
        tick();
        out_valid_i = 0; sel_i = 0; read_i = 0;
        n_checks++; if (data_o !== 8'hA5) begin n_err++; $display("FAIL same_cycle_data: got %h expected a5", data_o); end
        cpu_rd(2'd3);
        n_checks++; if (data_o !== 8'h01) begin n_err++; $display("FAIL same_cycle_count: got %h expected 01", data_o); end
        cpu_wr(2'd0, 8'h33);
        n_checks++; if (in_valid_o !== 1'b1) begin n_err++; $display("FAIL pre_rst_valid: got %b expected 1", in_valid_o); end
        #2 rst_i = 1;
        #1;
        n_checks++; if (in_valid_o !== 1'b0 || out_ready_o !== 1'b0) begin n_err++; $display("FAIL async_rst: got v=%b r=%b expected 0 0", in_valid_o, out_ready_o); end
        tick();
        rst_i = 0;
        cpu_rd(2'd3);
        n_checks++; if (data_o !== 8'h00 || in_valid_o !== 1'b0) begin n_err++; $display("FAIL post_rst: got cnt=%h v=%b expected 00 0", data_o, in_valid_o); end
    endtask

    task automatic test_random;
        logic [7:0] rxq[$];
        logic [7:0] txq[$];
        logic       m_ovf, m_udr, m_rirq, m_tirq;
        logic [1:0] m_en;
        logic [7:0] m_dout;
        int         rxn, txn, rd_pct, ir_pct, op;
        logic       rd, wr;
        do_reset();
        m_ovf = 0; m_udr = 0; m_rirq = 0; m_tirq = 0; m_en = 0; m_dout = 0;
        for (int c = 0; c < 800; c++) begin
            rd_pct = ((c / 100) % 2 == 1) ? 45 : 10;
            ir_pct = ((c / 130) % 2 == 1) ? 60 : 8;
            out_valid_i = ($urandom_range(0, 99) < 50);
            out_data_i  = 8'($urandom);
            in_ready_i  = ($urandom_range(0, 99) < ir_pct);
            op          = $urandom_range(0, 99);
            read_i      = (op < rd_pct);
            write_i     = (op >= 50 && op < 80) || (op >= 95);
            sel_i       = ($urandom_range(0, 99) < 90);
            addr_i      = ($urandom_range(0, 99) < 55) ? 2'd0 : 2'($urandom_range(1, 3));
            data_i      = 8'($urandom);

            rxn = rxq.size(); txn = txq.size();
            n_checks++; if (out_ready_o !== (rxn < DEPTH)) begin n_err++; $display("FAIL rnd_out_ready c=%0d: got %b expected %b", c, out_ready_o, rxn < DEPTH); end
            n_checks++; if (in_valid_o !== (txn != 0)) begin n_err++; $display("FAIL rnd_in_valid c=%0d: got %b expected %b", c, in_valid_o, txn != 0); end
            if (txn != 0) begin
                n_checks++; if (in_data_o !== txq[0]) begin n_err++; $display("FAIL rnd_in_data c=%0d: got %h expected %h", c, in_data_o, txq[0]); end
            end
            n_checks++; if (data_o !== m_dout) begin n_err++; $display("FAIL rnd_data_o c=%0d: got %h expected %h", c, data_o, m_dout); end
            n_checks++; if ({rx_irq_o, tx_irq_o} !== {m_rirq, m_tirq}) begin n_err++; $display("FAIL rnd_irq c=%0d: got %b%b expected %b%b", c, rx_irq_o, tx_irq_o, m_rirq, m_tirq); end

            rd = sel_i & read_i; wr = sel_i & write_i;
            m_rirq = m_en[0] && (rxn != 0);
            m_tirq = m_en[1] && (txn == 0);
            if (rd) begin
                case (addr_i)
                    2'd0: m_dout = (rxn != 0) ? rxq[0] : 8'h00;
                    2'd1: m_dout = {3'b000, txn == 0, m_udr, m_ovf, txn < DEPTH, rxn != 0};
                    2'd2: m_dout = {6'b0, m_en};
                    default: m_dout = 8'(rxn);
                endcase
            end
            if (wr && addr_i == 2'd1) begin
                if (data_i[2]) m_ovf = 0;
                if (data_i[3]) m_udr = 0;
            end
            if (wr && addr_i == 2'd2) m_en = data_i[1:0];
            if (rd && addr_i == 2'd0) begin
                if (rxn != 0) void'(rxq.pop_front()); else m_udr = 1;
            end
            if (out_valid_i && rxn < DEPTH) rxq.push_back(out_data_i);
            if (in_ready_i && txn != 0) void'(txq.pop_front());
            if (wr && addr_i == 2'd0) begin
                if (txn < DEPTH) txq.push_back(data_i); else m_ovf = 1;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst_i = 1;
        idle_inputs();
        test_reset();
        test_rx_basic();
        test_rx_full();
        test_tx();
        test_irq();
        test_same_cycle_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
